spi_burst_memory: RTL

//  SPI-slave-addressed register memory, parametrised in data width, address width and clock polarity.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_pin_sync.sv | 25 ++
 rtl/spi_burst_memory.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst memory: FSM encoding, header layout and
// synchroniser depth.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_RD_FETCH  = 3'd2,
        ST_RD_SHIFT  = 3'd3,
        ST_WR_SHIFT  = 3'd4,
        ST_WR_COMMIT = 3'd5,
        ST_DONE      = 3'd6
    } spi_state_e;

    localparam int RW_BIT      = 0;
    localparam int SYNC_STAGES = 2;

    // One counter serves both the header and the data phases.
    function automatic int cnt_width(input int data_w, input int addr_w);
        return $clog2(((data_w > addr_w) ? data_w : addr_w) + 1);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin with single-cycle rise/fall pulses.
// Deliberately not reset, so a reset in mid-transfer cannot fake a CS edge.
module spi_pin_sync
    import spi_pkg::*;
(
    input  logic clk,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI-slave register memory with auto-incrementing burst reads and writes;
// all pins are oversampled on clk.
module spi_burst_memory
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter bit CPOL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk_pin,
    input  logic              cs_pin,
    input  logic              mosi_pin,
    output logic              miso_pin,
    output logic              miso_oe,
    output logic              busy,
    output logic              word_done,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int CNT_W = cnt_width(DATA_W, ADDR_W);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sample_edge, drive_edge;
    logic unused_sync;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] hdr_q, hdr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              wd_q, wd_d;
    logic [ADDR_W:0]   hdr_full;
    logic              mem_we;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    spi_pin_sync u_sync_sclk (
        .clk    (clk),
        .pin_i  (sclk_pin),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_pin_sync u_sync_cs (
        .clk    (clk),
        .pin_i  (cs_pin),
        .level_o(cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_pin_sync u_sync_mosi (
        .clk    (clk),
        .pin_i  (mosi_pin),
        .level_o(mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_sync = sclk_lvl ^ cs_lvl ^ mosi_rise ^ mosi_fall;

    assign sample_edge = CPOL ? sclk_fall : sclk_rise;
    assign drive_edge  = CPOL ? sclk_rise : sclk_fall;
    assign hdr_full    = {hdr_q, mosi_lvl};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hdr_d   = hdr_q;
        addr_d  = addr_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        wd_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                oe_d   = 1'b0;
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = ST_HDR;
                    cnt_d   = '0;
                end
            end
            ST_HDR: begin
                if (sample_edge) begin
                    hdr_d = {hdr_q[ADDR_W-2:0], mosi_lvl};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_W)) begin
                        addr_d  = hdr_full[ADDR_W:1];
                        cnt_d   = '0;
                        state_d = hdr_full[RW_BIT] ? ST_RD_FETCH : ST_WR_SHIFT;
                    end
                end
            end
            ST_RD_FETCH: begin
                // Cycle 0 issues the memory read, cycle 1 loads its result.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q != '0) begin
                    shift_d = rd_data_q;
                    cnt_d   = '0;
                    state_d = ST_RD_SHIFT;
                end
            end
            ST_RD_SHIFT: begin
                oe_d = 1'b1;
                if (drive_edge) begin
                    miso_d  = shift_q[DATA_W-1];
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                end
                if (sample_edge) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        wd_d    = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = '0;
                        state_d = ST_RD_FETCH;
                    end
                end
            end
            ST_WR_SHIFT: begin
                if (sample_edge) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_lvl};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WR_COMMIT;
                    end
                end
            end
            ST_WR_COMMIT: begin
                wd_d    = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = '0;
                state_d = ST_WR_SHIFT;
            end
            ST_DONE: begin
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // CS release wins over a coincident sample edge; only a commit already
        // under way is allowed to finish.
        if (cs_rise && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            shift_d = shift_q;
            hdr_d   = hdr_q;
            miso_d  = miso_q;
            if (state_q != ST_WR_COMMIT) begin
                addr_d = addr_q;
                wd_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            hdr_q   <= '0;
            addr_q  <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            wd_q    <= wd_d;
        end
    end

    assign mem_we = (state_q == ST_WR_COMMIT) && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= shift_q;
        end
        rd_data_q <= mem_q[addr_q];
    end

    assign miso_pin  = miso_q & oe_q;
    assign miso_oe   = oe_q;
    assign busy      = (state_q != ST_IDLE);
    assign word_done = wd_q;
    assign cur_addr  = addr_q;

endmodule
